// File: rtl/move_referee.sv
// TicTacToe game-control stage: validates move requests, alternates X/O turns,
// enforces a per-turn timeout with an auto-placed mark, and detects win/draw.
module move_referee #(
    parameter int unsigned TURN_CYCLES = 750000000,
    parameter int unsigned TIMER_W     = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_game,
    input  logic               move_valid,
    input  logic [3:0]         move_pos,
    output logic [8:0]         board_x,
    output logic [8:0]         board_o,
    output logic               turn,
    output logic               move_ack,
    output logic               move_err,
    output logic               auto_move,
    output logic [TIMER_W-1:0] time_left,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [8:0]         win_line
);

    localparam logic [1:0] ST_PLAY  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [TIMER_W-1:0] TIME_RELOAD = TIMER_W'(TURN_CYCLES - 1);

    // Index 0 is the highest-priority line: rows, then columns, then diagonals.
    localparam logic [7:0][8:0] LINES = {
        9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
    };

    logic [1:0]  state;
    logic [8:0]  occupied;
    logic [15:0] occupied_ext;
    logic        req_legal;
    logic [8:0]  req_mask;
    logic [8:0]  auto_mask;
    logic [8:0]  mover_board;
    logic        line_hit;
    logic [8:0]  line_mask;

    assign occupied     = board_x | board_o;
    assign occupied_ext = {7'd0, occupied};
    assign req_legal    = (move_pos <= 4'd8) && !occupied_ext[move_pos];
    assign req_mask     = 9'(1) << move_pos;
    assign mover_board  = turn ? board_o : board_x;

    // Descending scan so the lowest free cell is the one left standing.
    always_comb begin
        auto_mask = '0;
        for (int i = 8; i >= 0; i--) begin
            if (!occupied[i]) auto_mask = 9'(1) << i;
        end
    end

    always_comb begin
        line_hit  = 1'b0;
        line_mask = '0;
        for (int i = 7; i >= 0; i--) begin
            if ((mover_board & LINES[i]) == LINES[i]) begin
                line_hit  = 1'b1;
                line_mask = LINES[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: pulses default low every cycle with non-blocking assignments;
        // later assignments in this block override the default for that cycle only.
        move_ack  <= 1'b0;
        move_err  <= 1'b0;
        auto_move <= 1'b0;
        if (rst || new_game) begin
            state     <= ST_PLAY;
            board_x   <= '0;
            board_o   <= '0;
            turn      <= 1'b0;
            time_left <= TIME_RELOAD;
            game_over <= 1'b0;
            winner    <= 2'b00;
            win_line  <= '0;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (move_valid && req_legal) begin
                        if (turn) board_o <= board_o | req_mask;
                        else      board_x <= board_x | req_mask;
                        move_ack <= 1'b1;
                        state    <= ST_CHECK;
                    end else if (time_left == '0) begin
                        // A rejected request and the timeout may fire together.
                        if (turn) board_o <= board_o | auto_mask;
                        else      board_x <= board_x | auto_mask;
                        auto_move <= 1'b1;
                        move_err  <= move_valid;
                        state     <= ST_CHECK;
                    end else begin
                        time_left <= time_left - 1'b1;
                        move_err  <= move_valid;
                    end
                end
                ST_CHECK: begin
                    if (line_hit) begin
                        winner    <= turn ? 2'b10 : 2'b01;
                        win_line  <= line_mask;
                        game_over <= 1'b1;
                        state     <= ST_DONE;
                    end else if (&occupied) begin
                        winner    <= 2'b11;
                        game_over <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        turn      <= ~turn;
                        time_left <= TIME_RELOAD;
                        state     <= ST_PLAY;
                    end
                end
                ST_DONE: begin
                    move_err <= move_valid;
                end
                default: begin
                    state <= ST_PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_referee.sv
// Self-checking bench for move_referee: directed scenarios followed by random
// play, all compared against a cell-array game model kept in this file.
module tb_move_referee;

    localparam int TURN_CYCLES = 8;
    localparam int TIMER_W     = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               new_game = 1'b0;
    logic               move_valid = 1'b0;
    logic [3:0]         move_pos = '0;
    logic [8:0]         board_x;
    logic [8:0]         board_o;
    logic               turn;
    logic               move_ack;
    logic               move_err;
    logic               auto_move;
    logic [TIMER_W-1:0] time_left;
    logic               game_over;
    logic [1:0]         winner;
    logic [8:0]         win_line;

    move_referee #(.TURN_CYCLES(TURN_CYCLES), .TIMER_W(TIMER_W)) dut (
        .clk(clk), .rst(rst), .new_game(new_game),
        .move_valid(move_valid), .move_pos(move_pos),
        .board_x(board_x), .board_o(board_o), .turn(turn),
        .move_ack(move_ack), .move_err(move_err), .auto_move(auto_move),
        .time_left(time_left), .game_over(game_over),
        .winner(winner), .win_line(win_line)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Game model: cell value 0 empty, 1 X, 2 O.
    int cells [9];
    int m_turn, m_timer, m_winner, m_line;
    bit m_checking, m_over;
    bit e_ack, e_err, e_auto;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mask_of(input int who);
        int m = 0;
        for (int i = 0; i < 9; i++) if (cells[i] == who) m |= (1 << i);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) cells[i] = 0;
        m_turn = 0; m_timer = TURN_CYCLES - 1; m_winner = 0; m_line = 0;
        m_checking = 0; m_over = 0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        int mover, found, empty, pos;
        e_ack = 0; e_err = 0; e_auto = 0;
        pos = int'(move_pos);
        if (rst || new_game) begin
            model_reset();
        end else if (m_over) begin
            e_err = move_valid;
        end else if (m_checking) begin
            m_checking = 0;
            mover = m_turn + 1;
            found = -1;
            for (int l = 0; l < 8; l++)
                if (found < 0 && cells[lines[l][0]] == mover &&
                    cells[lines[l][1]] == mover && cells[lines[l][2]] == mover)
                    found = l;
            empty = 0;
            for (int i = 0; i < 9; i++) if (cells[i] == 0) empty++;
            if (found >= 0) begin
                m_winner = mover;
                m_line = (1 << lines[found][0]) | (1 << lines[found][1]) | (1 << lines[found][2]);
                m_over = 1;
            end else if (empty == 0) begin
                m_winner = 3;
                m_over = 1;
            end else begin
                m_turn ^= 1;
                m_timer = TURN_CYCLES - 1;
            end
        end else if (move_valid && pos < 9 && cells[pos] == 0) begin
            cells[pos] = m_turn + 1;
            e_ack = 1;
            m_checking = 1;
        end else begin
            e_err = move_valid;
            if (m_timer == 0) begin
                found = -1;
                for (int i = 0; i < 9; i++) if (found < 0 && cells[i] == 0) found = i;
                cells[found] = m_turn + 1;
                e_auto = 1;
                m_checking = 1;
            end else begin
                m_timer--;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".board_x"},   32'(board_x),   32'(mask_of(1)));
        check({tag, ".board_o"},   32'(board_o),   32'(mask_of(2)));
        check({tag, ".turn"},      32'(turn),      32'(m_turn));
        check({tag, ".move_ack"},  32'(move_ack),  32'(e_ack));
        check({tag, ".move_err"},  32'(move_err),  32'(e_err));
        check({tag, ".auto_move"}, 32'(auto_move), 32'(e_auto));
        check({tag, ".time_left"}, 32'(time_left), 32'(m_timer));
        check({tag, ".game_over"}, 32'(game_over), 32'(m_over));
        check({tag, ".winner"},    32'(winner),    32'(m_winner));
        check({tag, ".win_line"},  32'(win_line),  32'(m_line));
    endtask

    task automatic step(input string tag, input logic v, input logic [3:0] p,
                        input logic r, input logic ng);
        @(negedge clk);
        move_valid = v; move_pos = p; rst = r; new_game = ng;
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    // A move followed by the idle CHECK cycle.
    task automatic play(input string tag, input logic [3:0] p);
        step(tag, 1'b1, p, 1'b0, 1'b0);
        step(tag, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();

        // Reset state and first move.
        step("reset", 1'b0, 4'd0, 1'b1, 1'b0);
        check("reset_time_left", 32'(time_left), 32'(TURN_CYCLES - 1));
        step("x0", 1'b1, 4'd0, 1'b0, 1'b0);
        check("x0_ack", 32'(move_ack), 32'd1);
        check("x0_board_x", 32'(board_x), 32'h001);
        idle("x0_check", 1);
        check("x0_turn", 32'(turn), 32'd1);

        // Occupied and out-of-range requests by O.
        step("reset2", 1'b0, 4'd0, 1'b1, 1'b0);
        play("x4", 4'd4);
        step("o4_occupied", 1'b1, 4'd4, 1'b0, 1'b0);
        check("o4_err", 32'(move_err), 32'd1);
        check("o4_board_o", 32'(board_o), 32'h000);
        step("o12_range", 1'b1, 4'd12, 1'b0, 1'b0);
        check("o12_err", 32'(move_err), 32'd1);
        check("o12_turn", 32'(turn), 32'd1);

        // X wins on the main diagonal.
        step("reset3", 1'b0, 4'd0, 1'b1, 1'b0);
        play("w_x0", 4'd0); play("w_o1", 4'd1); play("w_x4", 4'd4);
        play("w_o2", 4'd2); play("w_x8", 4'd8);
        check("xwin_winner", 32'(winner), 32'h1);
        check("xwin_line", 32'(win_line), 32'h111);
        check("xwin_over", 32'(game_over), 32'd1);
        step("done_req", 1'b1, 4'd5, 1'b0, 1'b0);
        check("done_err", 32'(move_err), 32'd1);
        check("done_board_x", 32'(board_x), 32'h111);

        // new_game leaves DONE.
        step("new_game", 1'b0, 4'd0, 1'b0, 1'b1);
        check("ng_over", 32'(game_over), 32'd0);
        check("ng_winner", 32'(winner), 32'd0);

        // Draw.
        play("d_x0", 4'd0); play("d_o1", 4'd1); play("d_x2", 4'd2);
        play("d_o4", 4'd4); play("d_x3", 4'd3); play("d_o5", 4'd5);
        play("d_x7", 4'd7); play("d_o6", 4'd6); play("d_x8", 4'd8);
        check("draw_winner", 32'(winner), 32'h3);
        check("draw_line", 32'(win_line), 32'h000);
        check("draw_full", 32'(board_x | board_o), 32'h1FF);

        // Timeout auto-move for O.
        step("reset4", 1'b0, 4'd0, 1'b1, 1'b0);
        play("t_x0", 4'd0);
        idle("t_wait", TURN_CYCLES);
        check("timeout_auto", 32'(auto_move), 32'd1);
        check("timeout_board_o", 32'(board_o), 32'h002);
        idle("t_check", 1);
        check("timeout_turn", 32'(turn), 32'd0);

        // Illegal request colliding with timeout: err and auto together.
        idle("t2_wait", TURN_CYCLES - 1);
        step("t2_collide", 1'b1, 4'd0, 1'b0, 1'b0);
        check("collide_err", 32'(move_err), 32'd1);
        check("collide_auto", 32'(auto_move), 32'd1);
        check("collide_board_x", 32'(board_x), 32'h005);

        // Legal request at timeout wins over the auto-move.
        step("reset5", 1'b0, 4'd0, 1'b1, 1'b0);
        play("t3_x0", 4'd0);
        idle("t3_wait", TURN_CYCLES - 1);
        step("t3_o5", 1'b1, 4'd5, 1'b0, 1'b0);
        check("t3_board_o", 32'(board_o), 32'h020);
        check("t3_no_auto", 32'(auto_move), 32'd0);

        // rst beats a legal move in the same cycle.
        step("rst_move", 1'b1, 4'd2, 1'b1, 1'b0);
        check("rst_no_ack", 32'(move_ack), 32'd0);
        check("rst_board", 32'(board_x | board_o), 32'h000);

        // Random play.
        for (int i = 0; i < 4000; i++) begin
            logic v, r, ng;
            logic [3:0] p;
            v  = ($urandom_range(0, 2) == 0);
            p  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            r  = ($urandom_range(0, 399) == 0);
            ng = ($urandom_range(0, 149) == 0);
            step("rand", v, p, r, ng);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
